divider_ctrl: RTL and testbench

DIVIDER_CTRL -- requirements
Module: divider_ctrl

---
 rtl/divider_pkg.sv | 47 ++++
 rtl/divider_ctrl_period_counter.sv | 62 ++++++
 rtl/divider_ctrl.sv | 139 +++++++++++++
 tb/tb_divider_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Shared definitions for the divider controller: FSM state
//               encoding, rate codes and rate-to-terminal-count helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      RATE_1HZ   = 2'd0,
      RATE_2HZ   = 2'd1,
      RATE_10HZ  = 2'd2,
      RATE_100HZ = 2'd3
   } rate_e;

   // Output frequency in Hz for a rate code.
   function automatic int unsigned rate_hz(input rate_e r);
      int unsigned hz;
      case (r)
         RATE_1HZ:   hz = 1;
         RATE_2HZ:   hz = 2;
         RATE_10HZ:  hz = 10;
         RATE_100HZ: hz = 100;
         default:    hz = 1;
      endcase
      return hz;
   endfunction

   // Terminal count: last counter value of a period (period length - 1).
   function automatic int unsigned rate_tc(input int unsigned clk_hz, input rate_e r);
      return (clk_hz / rate_hz(r)) - 1;
   endfunction

   // First counter value at which the square wave is high, (TC+1)/2.
   function automatic int unsigned rate_half(input int unsigned clk_hz, input rate_e r);
      return (clk_hz / rate_hz(r)) / 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/divider_ctrl_period_counter.sv
`default_nettype none
// ============================================================================
// Module      : period_counter
// Description : Loadable CW-bit period counter with enable, synchronous clear
//               and terminal-count compare.
//   clk_in   in  : clock, rising edge
//   reset    in  : synchronous active-high reset
//   en       in  : advance the counter this cycle
//   clr      in  : force the counter to zero (highest priority)
//   load     in  : load load_val (below clr)
//   load_val in  : value for load
//   tc       in  : terminal count; counter wraps to 0 after this value
//   half_thr in  : threshold for the half output
//   wrap     out : counter sits at tc and is advancing this cycle
//   half     out : next counter value is >= half_thr (meant to be registered)
// Revision    : 1.0 - initial release
// ============================================================================
module period_counter #(
   parameter int unsigned CW = 26
) (
   input  logic          clk_in,
   input  logic          reset,
   input  logic          en,
   input  logic          clr,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic [CW-1:0] tc,
   input  logic [CW-1:0] half_thr,
   output logic          wrap,
   output logic          half
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign wrap = en && !clr && !load && (count_q == tc);

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (en) begin
         count_d = (count_q == tc) ? '0 : count_q + CW'(1);
      end
   end

   // Compared against the next value so that a registered copy lines up
   // with the counter register itself.
   assign half = (count_d >= half_thr);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/divider_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : divider_ctrl
// Description : Run/stop/single-step clock divider producing a tick strobe,
//               a 50% square wave and a tick counter at a selectable rate.
//   clk_in     in  : system clock, rising edge
//   reset      in  : synchronous active-high reset
//   start      in  : level request to enter RUN
//   stop       in  : level request to return to IDLE (highest priority)
//   step       in  : single-tick request, honoured only in IDLE
//   rate_sel   in  : rate code 0=1Hz 1=2Hz 2=10Hz 3=100Hz
//   rate_load  in  : one-cycle strobe capturing rate_sel
//   tick       out : one-cycle pulse per period
//   wave_out   out : 50% square wave, low in IDLE
//   running    out : high in RUN or STEP
//   tick_count out : ticks issued since reset, wraps at 16 bits
// Revision    : 1.0 - initial release
// ============================================================================
module divider_ctrl
   import divider_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned CW     = 26
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        step,
   input  logic [1:0]  rate_sel,
   input  logic        rate_load,
   output logic        tick,
   output logic        wave_out,
   output logic        running,
   output logic [15:0] tick_count
);

   state_e        state_q,      state_d;
   rate_e         rate_act_q,   rate_act_d;
   rate_e         rate_pend_q,  rate_pend_d;
   logic          tick_q,       tick_d;
   logic          wave_q,       wave_d;
   logic          running_q,    running_d;
   logic [15:0]   tick_count_q, tick_count_d;

   logic          cnt_en;
   logic          cnt_clr;
   logic          cnt_wrap;
   logic          cnt_half;
   logic [CW-1:0] tc_val;
   logic [CW-1:0] half_val;

   assign tc_val   = CW'(rate_tc(CLK_HZ, rate_act_q));
   assign half_val = CW'(rate_half(CLK_HZ, rate_act_q));

   // Next-state logic. A finished step lingers in STEP for the tick cycle
   // (tick_q high) so running drops one cycle after the tick.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (stop)       state_d = ST_IDLE;
            else if (start) state_d = ST_RUN;
            else if (step)  state_d = ST_STEP;
         end
         ST_RUN: begin
            if (stop) state_d = ST_IDLE;
         end
         ST_STEP: begin
            if (stop)        state_d = ST_IDLE;
            else if (start)  state_d = ST_RUN;
            else if (tick_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Counter is held at zero in IDLE, cleared on entry from IDLE and on
      // any return to IDLE; STEP->RUN keeps counting.
      cnt_clr = (state_q == ST_IDLE) || (state_d == ST_IDLE);
      cnt_en  = !cnt_clr;
   end

   period_counter #(
      .CW (CW)
   ) u_period_counter (
      .clk_in   (clk_in),
      .reset    (reset),
      .en       (cnt_en),
      .clr      (cnt_clr),
      .load     (1'b0),
      .load_val ('0),
      .tc       (tc_val),
      .half_thr (half_val),
      .wrap     (cnt_wrap),
      .half     (cnt_half)
   );

   // Rate handling and registered outputs.
   always_comb begin
      rate_pend_d = rate_load ? rate_e'(rate_sel) : rate_pend_q;
      rate_act_d  = rate_act_q;
      // Switch only while idle or at a period boundary so no period is cut.
      if ((state_q == ST_IDLE) || cnt_wrap) begin
         rate_act_d = rate_pend_d;
      end

      tick_d       = cnt_wrap;
      running_d    = (state_d != ST_IDLE);
      wave_d       = running_d && cnt_half;
      tick_count_d = cnt_wrap ? tick_count_q + 16'd1 : tick_count_q;
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         rate_act_q   <= RATE_1HZ;
         rate_pend_q  <= RATE_1HZ;
         tick_q       <= 1'b0;
         wave_q       <= 1'b0;
         running_q    <= 1'b0;
         tick_count_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         rate_act_q   <= rate_act_d;
         rate_pend_q  <= rate_pend_d;
         tick_q       <= tick_d;
         wave_q       <= wave_d;
         running_q    <= running_d;
         tick_count_q <= tick_count_d;
      end
   end

   assign tick       = tick_q;
   assign wave_out   = wave_q;
   assign running    = running_q;
   assign tick_count = tick_count_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_ctrl
// Description : Self-checking bench for divider_ctrl at CLK_HZ=1000.
//               Expected ticks (cycle, tick_count) are queued as stimulus is
//               driven and checked by a monitor when tick is observed.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_divider_ctrl;

   localparam int unsigned CLK_HZ = 1000;
   localparam int unsigned CW     = 16;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        start;
   logic        stop;
   logic        step;
   logic [1:0]  rate_sel;
   logic        rate_load;
   logic        tick;
   logic        wave_out;
   logic        running;
   logic [15:0] tick_count;

   divider_ctrl #(
      .CLK_HZ (CLK_HZ),
      .CW     (CW)
   ) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .step       (step),
      .rate_sel   (rate_sel),
      .rate_load  (rate_load),
      .tick       (tick),
      .wave_out   (wave_out),
      .running    (running),
      .tick_count (tick_count)
   );

   always #5 clk_in = ~clk_in;

   // Number of rising edges so far; read on falling edges.
   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      int          c;
      logic [15:0] n;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] exp_cnt = 16'd0;
   int          n_cmp   = 0;
   int          n_bad   = 0;

   // Scoreboard push: a tick is required at cycle c carrying the next count.
   task automatic expect_tick(input int c);
      exp_t e;
      exp_cnt = exp_cnt + 16'd1;
      e.c = c;
      e.n = exp_cnt;
      exp_q.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk_in);
   endtask

   task automatic load_rate(input logic [1:0] r);
      rate_sel  = r;
      rate_load = 1'b1;
      @(negedge clk_in);
      rate_load = 1'b0;
   endtask

   // Tick monitor: pops the scoreboard whenever a tick is observed.
   always @(negedge clk_in) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
         e = exp_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missed_tick: no tick at cycle %0d, required at cycle %0d", cyc, e.c);
      end
      if (tick !== 1'b0) begin
         n_cmp++;
         if (exp_q.size() == 0 || exp_q[0].c != cyc) begin
            n_bad++;
            $display("FAIL unexpected_tick: tick=%b at cycle %0d, required 0", tick, cyc);
         end else begin
            e = exp_q.pop_front();
            if (tick_count !== e.n) begin
               n_bad++;
               $display("FAIL tick_count_at_tick: got %0d at cycle %0d, required %0d",
                        tick_count, cyc, e.n);
            end
         end
      end
   end

   task automatic test_reset();
      n_cmp++; if (tick !== 1'b0)        begin n_bad++; $display("FAIL reset_tick: got %b, required 0", tick); end
      n_cmp++; if (wave_out !== 1'b0)    begin n_bad++; $display("FAIL reset_wave: got %b, required 0", wave_out); end
      n_cmp++; if (running !== 1'b0)     begin n_bad++; $display("FAIL reset_running: got %b, required 0", running); end
      n_cmp++; if (tick_count !== 16'd0) begin n_bad++; $display("FAIL reset_tick_count: got %0d, required 0", tick_count); end
      reset = 1'b0;
      @(negedge clk_in);
      n_cmp++; if (running !== 1'b0)     begin n_bad++; $display("FAIL post_reset_running: got %b, required 0", running); end
   endtask

   task automatic test_wrap_timing();
      int t0;
      logic exp_w;
      load_rate(2'd3);
      start = 1'b1;
      t0 = cyc + 1;
      expect_tick(t0 + 10);
      expect_tick(t0 + 20);
      expect_tick(t0 + 30);
      @(negedge clk_in);
      start = 1'b0;
      for (int k = 0; k < 30; k++) begin
         exp_w = ((k % 10) >= 5);
         n_cmp++;
         if (wave_out !== exp_w) begin
            n_bad++;
            $display("FAIL wave_phase: got %b at period offset %0d, required %b", wave_out, k % 10, exp_w);
         end
         n_cmp++;
         if (running !== 1'b1) begin
            n_bad++;
            $display("FAIL run_running: got %b at offset %0d, required 1", running, k);
         end
         @(negedge clk_in);
      end
      n_cmp++;
      if (tick_count !== 16'd3) begin
         n_bad++;
         $display("FAIL tick_count_30: got %0d, required 3", tick_count);
      end
      stop = 1'b1;
      @(negedge clk_in);
      stop = 1'b0;
      n_cmp++; if (running !== 1'b0)  begin n_bad++; $display("FAIL stop_running: got %b, required 0", running); end
      n_cmp++; if (wave_out !== 1'b0) begin n_bad++; $display("FAIL stop_wave: got %b, required 0", wave_out); end
   endtask

   task automatic test_rate_change();
      int t0;
      load_rate(2'd2);
      start = 1'b1;
      t0 = cyc + 1;
      expect_tick(t0 + 100);
      expect_tick(t0 + 110);
      expect_tick(t0 + 120);
      @(negedge clk_in);
      start = 1'b0;
      wait_until(t0 + 40);
      n_cmp++; if (wave_out !== 1'b0) begin n_bad++; $display("FAIL rate2_wave_40: got %b, required 0", wave_out); end
      rate_sel  = 2'd3;
      rate_load = 1'b1;
      @(negedge clk_in);
      rate_load = 1'b0;
      wait_until(t0 + 75);
      n_cmp++; if (wave_out !== 1'b1) begin n_bad++; $display("FAIL rate2_wave_75: got %b, required 1", wave_out); end
      wait_until(t0 + 104);
      n_cmp++; if (wave_out !== 1'b0) begin n_bad++; $display("FAIL rate3_wave_4: got %b, required 0", wave_out); end
      wait_until(t0 + 115);
      n_cmp++; if (wave_out !== 1'b1) begin n_bad++; $display("FAIL rate3_wave_5: got %b, required 1", wave_out); end
      wait_until(t0 + 120);
      stop = 1'b1;
      @(negedge clk_in);
      stop = 1'b0;
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL rate_stop_running: got %b, required 0", running); end
   endtask

   task automatic test_single_step();
      int t0;
      step = 1'b1;
      t0 = cyc + 1;
      expect_tick(t0 + 10);
      @(negedge clk_in);
      step = 1'b0;
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL step_running_start: got %b, required 1", running); end
      wait_until(t0 + 5);
      step = 1'b1;
      @(negedge clk_in);
      step = 1'b0;
      wait_until(t0 + 10);
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL step_running_tick: got %b, required 1", running); end
      @(negedge clk_in);
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL step_running_after: got %b, required 0", running); end
      wait_until(t0 + 40);
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL step_idle_later: got %b, required 0", running); end
      n_cmp++; if (tick_count !== exp_cnt) begin n_bad++; $display("FAIL step_tick_count: got %0d, required %0d", tick_count, exp_cnt); end
   endtask

   task automatic test_priority();
      int t0;
      // start and stop together in IDLE
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
      stop  = 1'b0;
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL prio_idle_running: got %b, required 0", running); end
      repeat (12) @(negedge clk_in);
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL prio_idle_later: got %b, required 0", running); end
      // stop in RUN at counter 7
      start = 1'b1;
      t0 = cyc + 1;
      @(negedge clk_in);
      start = 1'b0;
      wait_until(t0 + 7);
      n_cmp++; if (wave_out !== 1'b1) begin n_bad++; $display("FAIL prio_wave_7: got %b, required 1", wave_out); end
      stop = 1'b1;
      @(negedge clk_in);
      stop = 1'b0;
      n_cmp++; if (tick !== 1'b0)     begin n_bad++; $display("FAIL prio_stop_tick: got %b, required 0", tick); end
      n_cmp++; if (wave_out !== 1'b0) begin n_bad++; $display("FAIL prio_stop_wave: got %b, required 0", wave_out); end
      n_cmp++; if (running !== 1'b0)  begin n_bad++; $display("FAIL prio_stop_running: got %b, required 0", running); end
      wait_until(t0 + 25);
      // stop aborts a step
      step = 1'b1;
      t0 = cyc + 1;
      @(negedge clk_in);
      step = 1'b0;
      wait_until(t0 + 4);
      stop = 1'b1;
      @(negedge clk_in);
      stop = 1'b0;
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL abort_step_running: got %b, required 0", running); end
      wait_until(t0 + 20);
      // start during a step promotes to RUN without restarting the period
      step = 1'b1;
      t0 = cyc + 1;
      expect_tick(t0 + 10);
      expect_tick(t0 + 20);
      @(negedge clk_in);
      step = 1'b0;
      wait_until(t0 + 3);
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
      wait_until(t0 + 11);
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL promote_running: got %b, required 1", running); end
      wait_until(t0 + 20);
      stop = 1'b1;
      @(negedge clk_in);
      stop = 1'b0;
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL promote_stop: got %b, required 0", running); end
   endtask

   task automatic test_reset_mid();
      int t0;
      int t1;
      start = 1'b1;
      t0 = cyc + 1;
      @(negedge clk_in);
      start = 1'b0;
      wait_until(t0 + 9);
      n_cmp++; if (wave_out !== 1'b1) begin n_bad++; $display("FAIL mid_wave_9: got %b, required 1", wave_out); end
      reset = 1'b1;
      @(negedge clk_in);
      exp_cnt = 16'd0;
      n_cmp++; if (tick !== 1'b0)        begin n_bad++; $display("FAIL mid_reset_tick: got %b, required 0", tick); end
      n_cmp++; if (wave_out !== 1'b0)    begin n_bad++; $display("FAIL mid_reset_wave: got %b, required 0", wave_out); end
      n_cmp++; if (running !== 1'b0)     begin n_bad++; $display("FAIL mid_reset_running: got %b, required 0", running); end
      n_cmp++; if (tick_count !== 16'd0) begin n_bad++; $display("FAIL mid_reset_count: got %0d, required 0", tick_count); end
      reset = 1'b0;
      @(negedge clk_in);
      // rate must be back at 1 Hz: next tick 1000 cycles after start
      start = 1'b1;
      t1 = cyc + 1;
      expect_tick(t1 + 1000);
      @(negedge clk_in);
      start = 1'b0;
      wait_until(t1 + 999);
      n_cmp++; if (wave_out !== 1'b1) begin n_bad++; $display("FAIL one_hz_wave: got %b, required 1", wave_out); end
      wait_until(t1 + 1000);
      stop = 1'b1;
      @(negedge clk_in);
      stop = 1'b0;
   endtask

   task automatic test_count_wrap();
      int t0;
      load_rate(2'd3);
      force dut.tick_count_q = 16'hFFFF;
      exp_cnt = 16'hFFFF;
      @(negedge clk_in);
      release dut.tick_count_q;
      n_cmp++; if (tick_count !== 16'hFFFF) begin n_bad++; $display("FAIL preload_count: got %0d, required 65535", tick_count); end
      start = 1'b1;
      t0 = cyc + 1;
      expect_tick(t0 + 10);
      @(negedge clk_in);
      start = 1'b0;
      wait_until(t0 + 10);
      n_cmp++; if (tick_count !== 16'd0) begin n_bad++; $display("FAIL count_wrap: got %0d, required 0", tick_count); end
      stop = 1'b1;
      @(negedge clk_in);
      stop = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      step      = 1'b0;
      rate_sel  = 2'd0;
      rate_load = 1'b0;
      repeat (3) @(negedge clk_in);

      test_reset();
      test_wrap_timing();
      test_rate_change();
      test_single_step();
      test_priority();
      test_reset_mid();
      test_count_wrap();

      repeat (5) @(negedge clk_in);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL pending_ticks: %0d required ticks never seen, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
